// File: rtl/mouse_master_sm_if.sv
// -----------------------------------------------------------------------------
// mouse_master_sm_if
// Bundles the PS/2 host controller's links: the command handshake to the
// mouse transmitter, the byte stream from the mouse receiver, and the packet
// registers plus interrupt pulse offered to downstream logic.
//
// Handshake semantics (all signals synchronous to the controller clock):
//   SEND_BYTE is a one-cycle request; BYTE_TO_SEND is valid in that cycle and
//   stays unchanged until the transmitter answers with a one-cycle BYTE_SENT.
//   BYTE_READY is a one-cycle strobe from the receiver; BYTE_RECEIVED and
//   BYTE_ERROR_CODE are valid only in that cycle. There is no back-pressure:
//   a strobe arriving in a state that is not waiting for it is dropped.
//   SEND_INTERRUPT is a one-cycle strobe; MOUSE_STATUS/DX/DY are valid from
//   that cycle and hold until the next strobe.
//
// Modports:
//   master - the host controller (drives commands, packet outputs)
//   slave  - the transmitter/receiver/consumer side
// -----------------------------------------------------------------------------
interface mouse_master_sm_if;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       BYTE_SENT;
  logic       READ_ENABLE;
  logic       BYTE_READY;
  logic [7:0] BYTE_RECEIVED;
  logic [1:0] BYTE_ERROR_CODE;
  logic [7:0] MOUSE_STATUS;
  logic [7:0] MOUSE_DX;
  logic [7:0] MOUSE_DY;
  logic       SEND_INTERRUPT;

  modport master (
    output SEND_BYTE, BYTE_TO_SEND, READ_ENABLE,
    output MOUSE_STATUS, MOUSE_DX, MOUSE_DY, SEND_INTERRUPT,
    input  BYTE_SENT, BYTE_READY, BYTE_RECEIVED, BYTE_ERROR_CODE
  );

  modport slave (
    input  SEND_BYTE, BYTE_TO_SEND, READ_ENABLE,
    input  MOUSE_STATUS, MOUSE_DX, MOUSE_DY, SEND_INTERRUPT,
    output BYTE_SENT, BYTE_READY, BYTE_RECEIVED, BYTE_ERROR_CODE
  );
endinterface

// File: rtl/mouse_master_sm.sv
// -----------------------------------------------------------------------------
// mouse_master_sm
// PS/2 mouse host controller. After reset it waits INIT_WAIT cycles, sends
// reset (0xFF), expects 0xFA/0xAA/0x00, sends enable (0xF4), expects 0xFA,
// then streams 3-byte movement packets into MOUSE_STATUS/DX/DY with a
// one-cycle SEND_INTERRUPT per packet. Any init-phase wait that lasts
// TIMEOUT cycles, or any unexpected/errored reply, restarts at INIT.
//
// Ports:
//   CLK          - system clock
//   RESET        - asynchronous active-high reset
//   bus          - mouse_master_sm_if.master (transmitter, receiver, packet out)
//   MASTER_STATE - current state encoding (debug)
//
// Optional build macro: MOUSE_WATCHDOG_EN
//   When defined, a packet stalled in RX_DX/RX_DY for TIMEOUT cycles is
//   dropped and the controller resyncs at RX_STATUS. When undefined those
//   states wait indefinitely.
// -----------------------------------------------------------------------------
module mouse_master_sm #(
  parameter int INIT_WAIT = 5000000,
  parameter int TIMEOUT   = 50000000,
  parameter int CNT_W     = 26
) (
  input  logic                 CLK,
  input  logic                 RESET,
  mouse_master_sm_if.master    bus,
  output logic [3:0]           MASTER_STATE
);

  typedef enum logic [3:0] {
    S_INIT         = 4'd0,
    S_SEND_FF      = 4'd1,
    S_WAIT_SENT_FF = 4'd2,
    S_WAIT_ACK     = 4'd3,
    S_WAIT_BAT     = 4'd4,
    S_WAIT_ID      = 4'd5,
    S_SEND_F4      = 4'd6,
    S_WAIT_SENT_F4 = 4'd7,
    S_WAIT_ACK_F4  = 4'd8,
    S_RX_STATUS    = 4'd9,
    S_RX_DX        = 4'd10,
    S_RX_DY        = 4'd11,
    S_REPORT       = 4'd12
  } state_t;

  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_WAIT - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt, cnt_next;

  logic             byte_ok;
  logic             init_phase;
  logic             timeout_hit;
  logic             count_en;

  logic [7:0]       shadow_status, shadow_dx, shadow_dy;

  logic             send_byte_d;
  logic [7:0]       byte_to_send_d;
  logic             read_enable_d;
  logic             send_interrupt_d;
  logic [7:0]       mouse_status_d, mouse_dx_d, mouse_dy_d;

  assign MASTER_STATE = state;

  assign byte_ok     = bus.BYTE_READY && (bus.BYTE_ERROR_CODE == 2'b00);
  // States 2..8 are the guarded init-phase waits.
  assign init_phase  = (state >= S_WAIT_SENT_FF) && (state <= S_WAIT_ACK_F4);
  assign timeout_hit = (cnt == TO_LAST);

  // ---------------------------------------------------------------------------
  // State and counter registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= S_INIT;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    case (state)
      S_INIT:         if (cnt == INIT_LAST) next_state = S_SEND_FF;
      S_SEND_FF:      next_state = S_WAIT_SENT_FF;
      S_WAIT_SENT_FF: if (bus.BYTE_SENT) next_state = S_WAIT_ACK;
      S_WAIT_ACK:
        if (bus.BYTE_READY)
          next_state = (byte_ok && bus.BYTE_RECEIVED == 8'hFA) ? S_WAIT_BAT : S_INIT;
      S_WAIT_BAT:
        if (bus.BYTE_READY)
          next_state = (byte_ok && bus.BYTE_RECEIVED == 8'hAA) ? S_WAIT_ID : S_INIT;
      S_WAIT_ID:
        if (bus.BYTE_READY)
          next_state = (byte_ok && bus.BYTE_RECEIVED == 8'h00) ? S_SEND_F4 : S_INIT;
      S_SEND_F4:      next_state = S_WAIT_SENT_F4;
      S_WAIT_SENT_F4: if (bus.BYTE_SENT) next_state = S_WAIT_ACK_F4;
      S_WAIT_ACK_F4:
        if (bus.BYTE_READY)
          next_state = (byte_ok && bus.BYTE_RECEIVED == 8'hFA) ? S_RX_STATUS : S_INIT;
      // Bit 3 of a status byte is always set; a clear bit 3 means we are
      // mid-packet, so the byte is skipped until alignment is found.
      S_RX_STATUS:
        if (byte_ok && bus.BYTE_RECEIVED[3]) next_state = S_RX_DX;
      S_RX_DX: begin
        if (bus.BYTE_READY)
          next_state = byte_ok ? S_RX_DY : S_RX_STATUS;
`ifdef MOUSE_WATCHDOG_EN
        else if (timeout_hit)
          next_state = S_RX_STATUS;
`endif
      end
      S_RX_DY: begin
        if (bus.BYTE_READY)
          next_state = byte_ok ? S_REPORT : S_RX_STATUS;
`ifdef MOUSE_WATCHDOG_EN
        else if (timeout_hit)
          next_state = S_RX_STATUS;
`endif
      end
      S_REPORT:       next_state = S_RX_STATUS;
      default:        next_state = S_INIT;
    endcase

    // The timeout outranks any reply arriving in the same cycle.
    if (init_phase && timeout_hit) next_state = S_INIT;
  end

  // Counter clears on every state change and otherwise runs only where a
  // wait is being measured.
  always_comb begin
    count_en = (state == S_INIT) || init_phase;
`ifdef MOUSE_WATCHDOG_EN
    if (state == S_RX_DX || state == S_RX_DY) count_en = 1'b1;
`endif
    if (next_state != state) cnt_next = '0;
    else if (count_en)       cnt_next = cnt + CNT_W'(1);
    else                     cnt_next = '0;
  end

  // ---------------------------------------------------------------------------
  // Packet shadow registers: bytes are held here until the whole packet is
  // good, so a dropped packet never disturbs the visible MOUSE_* registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      shadow_status <= 8'h00;
      shadow_dx     <= 8'h00;
      shadow_dy     <= 8'h00;
    end else begin
      if (state == S_RX_STATUS && byte_ok && bus.BYTE_RECEIVED[3])
        shadow_status <= bus.BYTE_RECEIVED;
      if (state == S_RX_DX && byte_ok)
        shadow_dx <= bus.BYTE_RECEIVED;
      if (state == S_RX_DY && byte_ok)
        shadow_dy <= bus.BYTE_RECEIVED;
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic: decoded from the current state, then registered, so every
  // output appears one cycle after the state that produces it.
  // ---------------------------------------------------------------------------
  always_comb begin
    send_byte_d      = 1'b0;
    byte_to_send_d   = bus.BYTE_TO_SEND;
    read_enable_d    = 1'b0;
    send_interrupt_d = 1'b0;
    mouse_status_d   = bus.MOUSE_STATUS;
    mouse_dx_d       = bus.MOUSE_DX;
    mouse_dy_d       = bus.MOUSE_DY;
    case (state)
      S_SEND_FF: begin
        send_byte_d    = 1'b1;
        byte_to_send_d = 8'hFF;
      end
      S_SEND_F4: begin
        send_byte_d    = 1'b1;
        byte_to_send_d = 8'hF4;
      end
      S_WAIT_ACK, S_WAIT_BAT, S_WAIT_ID, S_WAIT_ACK_F4,
      S_RX_STATUS, S_RX_DX, S_RX_DY:
        read_enable_d = 1'b1;
      S_REPORT: begin
        send_interrupt_d = 1'b1;
        mouse_status_d   = shadow_status;
        mouse_dx_d       = shadow_dx;
        mouse_dy_d       = shadow_dy;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      bus.SEND_BYTE      <= 1'b0;
      bus.BYTE_TO_SEND   <= 8'h00;
      bus.READ_ENABLE    <= 1'b0;
      bus.SEND_INTERRUPT <= 1'b0;
      bus.MOUSE_STATUS   <= 8'h00;
      bus.MOUSE_DX       <= 8'h00;
      bus.MOUSE_DY       <= 8'h00;
    end else begin
      bus.SEND_BYTE      <= send_byte_d;
      bus.BYTE_TO_SEND   <= byte_to_send_d;
      bus.READ_ENABLE    <= read_enable_d;
      bus.SEND_INTERRUPT <= send_interrupt_d;
      bus.MOUSE_STATUS   <= mouse_status_d;
      bus.MOUSE_DX       <= mouse_dx_d;
      bus.MOUSE_DY       <= mouse_dy_d;
    end
  end

endmodule

// File: tb/tb_mouse_master_sm.sv
// -----------------------------------------------------------------------------
// tb_mouse_master_sm
// Self-checking bench for mouse_master_sm with shortened INIT_WAIT/TIMEOUT.
// A negedge monitor pops expected commands and packets from scoreboard queues
// whenever SEND_BYTE or SEND_INTERRUPT fires; scenario tasks check state,
// timing and register values inline.
// -----------------------------------------------------------------------------
module tb_mouse_master_sm;
  localparam int INIT_WAIT = 20;
  localparam int TIMEOUT   = 60;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] master_state;

  mouse_master_sm_if m_if();

  mouse_master_sm #(
    .INIT_WAIT (INIT_WAIT),
    .TIMEOUT   (TIMEOUT),
    .CNT_W     (26)
  ) dut (
    .CLK          (clk),
    .RESET        (rst),
    .bus          (m_if.master),
    .MASTER_STATE (master_state)
  );

  // ---------------------------------------------------------------------------
  // Clock / global time limit
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_time_limit: simulation did not end, required end before limit");
    $fatal(1, "time limit");
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;
  int send_count = 0;
  int intr_count = 0;

  logic [7:0]  exp_q[$];
  logic [23:0] exp_pkt_q[$];
  logic [7:0]  exp_cmd;
  logic [23:0] exp_pkt;

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (m_if.SEND_BYTE === 1'b1) begin
        send_count++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL cmd_unexpected: got 0x%02h, required no request", m_if.BYTE_TO_SEND);
        end else begin
          exp_cmd = exp_q.pop_front();
          if (m_if.BYTE_TO_SEND !== exp_cmd) begin
            bad++;
            $display("FAIL cmd_byte: got 0x%02h, required 0x%02h", m_if.BYTE_TO_SEND, exp_cmd);
          end
        end
      end
      if (m_if.SEND_INTERRUPT === 1'b1) begin
        intr_count++;
        total++;
        if (exp_pkt_q.size() == 0) begin
          bad++;
          $display("FAIL pkt_unexpected: got %02h/%02h/%02h, required no interrupt",
                   m_if.MOUSE_STATUS, m_if.MOUSE_DX, m_if.MOUSE_DY);
        end else begin
          exp_pkt = exp_pkt_q.pop_front();
          if ({m_if.MOUSE_STATUS, m_if.MOUSE_DX, m_if.MOUSE_DY} !== exp_pkt) begin
            bad++;
            $display("FAIL pkt_value: got %02h/%02h/%02h, required %06h",
                     m_if.MOUSE_STATUS, m_if.MOUSE_DX, m_if.MOUSE_DY, exp_pkt);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic do_reset();
    total++;
    if (exp_q.size() != 0 || exp_pkt_q.size() != 0) begin
      bad++;
      $display("FAIL pending_before_reset: cmd=%0d pkt=%0d left, required 0/0",
               exp_q.size(), exp_pkt_q.size());
    end
    exp_q.delete();
    exp_pkt_q.delete();
    rst = 1'b1;
    m_if.BYTE_SENT       = 1'b0;
    m_if.BYTE_READY      = 1'b0;
    m_if.BYTE_RECEIVED   = 8'h00;
    m_if.BYTE_ERROR_CODE = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_sent();
    @(negedge clk);
    m_if.BYTE_SENT = 1'b1;
    @(negedge clk);
    m_if.BYTE_SENT = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] b, input logic [1:0] err);
    @(negedge clk);
    m_if.BYTE_READY      = 1'b1;
    m_if.BYTE_RECEIVED   = b;
    m_if.BYTE_ERROR_CODE = err;
    @(negedge clk);
    m_if.BYTE_READY      = 1'b0;
    m_if.BYTE_ERROR_CODE = 2'b00;
  endtask

  task automatic wait_state(input logic [3:0] s, input int budget, input string name);
    int n;
    n = 0;
    while (master_state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (master_state !== s) begin
      bad++;
      $display("FAIL %s: state=%0d, required %0d", name, master_state, s);
    end
  endtask

  task automatic init_to_f4();
    exp_q.push_back(8'hFF);
    wait_state(4'd2, INIT_WAIT + 5, "reach_wait_sent_ff");
    pulse_sent();
    wait_state(4'd3, 3, "reach_wait_ack");
    rx_byte(8'hFA, 2'b00);
    wait_state(4'd4, 3, "reach_wait_bat");
    rx_byte(8'hAA, 2'b00);
    wait_state(4'd5, 3, "reach_wait_id");
    rx_byte(8'h00, 2'b00);
    exp_q.push_back(8'hF4);
    wait_state(4'd7, 4, "reach_wait_sent_f4");
  endtask

  task automatic bring_up();
    init_to_f4();
    pulse_sent();
    wait_state(4'd8, 3, "reach_wait_ack_f4");
    rx_byte(8'hFA, 2'b00);
    wait_state(4'd9, 3, "reach_rx_status");
  endtask

  task automatic send_packet(input logic [7:0] s, input logic [7:0] dx, input logic [7:0] dy);
    exp_pkt_q.push_back({s, dx, dy});
    rx_byte(s, 2'b00);
    idle($urandom_range(0, 3));
    rx_byte(dx, 2'b00);
    idle($urandom_range(0, 3));
    rx_byte(dy, 2'b00);
    idle(3);
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b0;
    m_if.BYTE_SENT       = 1'b0;
    m_if.BYTE_READY      = 1'b0;
    m_if.BYTE_RECEIVED   = 8'h00;
    m_if.BYTE_ERROR_CODE = 2'b00;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (master_state !== 4'd0 || m_if.SEND_BYTE !== 1'b0 || m_if.READ_ENABLE !== 1'b0 ||
        m_if.SEND_INTERRUPT !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl: state=%0d send=%b ren=%b intr=%b, required 0/0/0/0",
               master_state, m_if.SEND_BYTE, m_if.READ_ENABLE, m_if.SEND_INTERRUPT);
    end
    total++;
    if ({m_if.BYTE_TO_SEND, m_if.MOUSE_STATUS, m_if.MOUSE_DX, m_if.MOUSE_DY} !== 32'h0) begin
      bad++;
      $display("FAIL reset_data: cmd=%02h st=%02h dx=%02h dy=%02h, required all 00",
               m_if.BYTE_TO_SEND, m_if.MOUSE_STATUS, m_if.MOUSE_DX, m_if.MOUSE_DY);
    end
    rst = 1'b0;
  endtask

  task automatic test_nominal_init();
    do_reset();
    send_count = 0;
    bring_up();
    idle(2);
    total++;
    if (send_count !== 2) begin
      bad++;
      $display("FAIL init_send_count: got %0d, required 2", send_count);
    end
    total++;
    if (m_if.READ_ENABLE !== 1'b1 || m_if.BYTE_TO_SEND !== 8'hF4) begin
      bad++;
      $display("FAIL init_streaming_outputs: ren=%b cmd=%02h, required 1/F4",
               m_if.READ_ENABLE, m_if.BYTE_TO_SEND);
    end
  endtask

  task automatic test_bad_ack();
    int n;
    do_reset();
    exp_q.push_back(8'hFF);
    wait_state(4'd2, INIT_WAIT + 5, "badack_wait_sent");
    pulse_sent();
    wait_state(4'd3, 3, "badack_wait_ack");
    rx_byte(8'hFE, 2'b00);
    total++;
    if (master_state !== 4'd0) begin
      bad++;
      $display("FAIL bad_ack_to_init: state=%0d, required 0", master_state);
    end
    exp_q.push_back(8'hFF);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_if.SEND_BYTE !== 1'b1 && n < INIT_WAIT + 10);
    total++;
    if (n !== INIT_WAIT + 1) begin
      bad++;
      $display("FAIL bad_ack_resend_delay: got %0d cycles, required %0d", n, INIT_WAIT + 1);
    end
    // A correct BAT byte flagged with a parity error must also restart.
    pulse_sent();
    wait_state(4'd3, 3, "badack_wait_ack2");
    rx_byte(8'hFA, 2'b00);
    wait_state(4'd4, 3, "badack_wait_bat");
    rx_byte(8'hAA, 2'b01);
    total++;
    if (master_state !== 4'd0) begin
      bad++;
      $display("FAIL bat_error_to_init: state=%0d, required 0", master_state);
    end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    exp_q.push_back(8'hFF);
    wait_state(4'd2, INIT_WAIT + 5, "to_wait_sent");
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        total++;
        if (m_if.READ_ENABLE !== 1'b0 || m_if.SEND_BYTE !== 1'b0 || m_if.BYTE_TO_SEND !== 8'hFF) begin
          bad++;
          $display("FAIL wait_sent_outputs: ren=%b send=%b cmd=%02h, required 0/0/FF",
                   m_if.READ_ENABLE, m_if.SEND_BYTE, m_if.BYTE_TO_SEND);
        end
      end
    end while (master_state !== 4'd0 && n < TIMEOUT + 10);
    total++;
    if (n !== TIMEOUT) begin
      bad++;
      $display("FAIL timeout_length: got %0d cycles, required %0d", n, TIMEOUT);
    end
    // BYTE_SENT on the timeout cycle itself must lose.
    exp_q.push_back(8'hFF);
    wait_state(4'd2, INIT_WAIT + 5, "to_wait_sent2");
    idle(TIMEOUT - 1);
    m_if.BYTE_SENT = 1'b1;
    @(negedge clk);
    m_if.BYTE_SENT = 1'b0;
    total++;
    if (master_state !== 4'd0) begin
      bad++;
      $display("FAIL timeout_beats_sent: state=%0d, required 0", master_state);
    end
  endtask

  task automatic test_streaming();
    do_reset();
    bring_up();
    intr_count = 0;
    rx_byte(8'h00, 2'b00);
    idle(1);
    total++;
    if (master_state !== 4'd9) begin
      bad++;
      $display("FAIL stream_discard_unsynced: state=%0d, required 9", master_state);
    end
    exp_pkt_q.push_back(24'h2805FB);
    rx_byte(8'h28, 2'b00);
    idle(2);
    rx_byte(8'h05, 2'b00);
    idle(1);
    rx_byte(8'hFB, 2'b00);
    total++;
    if (master_state !== 4'd12 || m_if.SEND_INTERRUPT !== 1'b0) begin
      bad++;
      $display("FAIL stream_report_entry: state=%0d intr=%b, required 12/0",
               master_state, m_if.SEND_INTERRUPT);
    end
    @(negedge clk);
    total++;
    if (m_if.SEND_INTERRUPT !== 1'b1) begin
      bad++;
      $display("FAIL stream_intr_latency: intr=%b, required 1", m_if.SEND_INTERRUPT);
    end
    @(negedge clk);
    total++;
    if (m_if.SEND_INTERRUPT !== 1'b0 || m_if.MOUSE_DY !== 8'hFB || master_state !== 4'd9) begin
      bad++;
      $display("FAIL stream_after_report: intr=%b dy=%02h state=%0d, required 0/FB/9",
               m_if.SEND_INTERRUPT, m_if.MOUSE_DY, master_state);
    end
    for (int i = 0; i < 3; i++) begin
      send_packet(8'($urandom_range(0, 255)) | 8'h08, 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)));
    end
    total++;
    if (intr_count !== 4) begin
      bad++;
      $display("FAIL stream_intr_count: got %0d, required 4", intr_count);
    end
  endtask

  task automatic test_packet_error();
    intr_count = 0;
    rx_byte(8'h18, 2'b00);
    rx_byte(8'h33, 2'b01);
    total++;
    if (master_state !== 4'd9) begin
      bad++;
      $display("FAIL dx_error_resync: state=%0d, required 9", master_state);
    end
    rx_byte(8'h08, 2'b10);
    total++;
    if (master_state !== 4'd9) begin
      bad++;
      $display("FAIL status_error_discard: state=%0d, required 9", master_state);
    end
    rx_byte(8'h08, 2'b00);
    rx_byte(8'h01, 2'b00);
    rx_byte(8'h02, 2'b10);
    total++;
    if (master_state !== 4'd9) begin
      bad++;
      $display("FAIL dy_error_resync: state=%0d, required 9", master_state);
    end
    send_packet(8'h18, 8'h44, 8'h55);
    total++;
    if (intr_count !== 1) begin
      bad++;
      $display("FAIL error_intr_count: got %0d, required 1", intr_count);
    end
  endtask

  task automatic test_async_reset();
    // Mid-stream: packet registers hold 18/44/55 and must clear at once.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({m_if.MOUSE_STATUS, m_if.MOUSE_DX, m_if.MOUSE_DY} !== 24'h0 || master_state !== 4'd0 ||
        m_if.READ_ENABLE !== 1'b0) begin
      bad++;
      $display("FAIL async_reset_stream: st=%02h dx=%02h dy=%02h state=%0d ren=%b, required 0",
               m_if.MOUSE_STATUS, m_if.MOUSE_DX, m_if.MOUSE_DY, master_state, m_if.READ_ENABLE);
    end
    #1 rst = 1'b0;
    init_to_f4();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (master_state !== 4'd0 || m_if.SEND_BYTE !== 1'b0 || m_if.BYTE_TO_SEND !== 8'h00 ||
        m_if.READ_ENABLE !== 1'b0 || m_if.SEND_INTERRUPT !== 1'b0) begin
      bad++;
      $display("FAIL async_reset_f4: state=%0d send=%b cmd=%02h ren=%b intr=%b, required 0/0/00/0/0",
               master_state, m_if.SEND_BYTE, m_if.BYTE_TO_SEND, m_if.READ_ENABLE, m_if.SEND_INTERRUPT);
    end
    #1 rst = 1'b0;
    exp_q.push_back(8'hFF);
    wait_state(4'd2, INIT_WAIT + 5, "async_restart");
    idle(2);
  endtask

`ifdef MOUSE_WATCHDOG_EN
  task automatic test_watchdog();
    do_reset();
    bring_up();
    intr_count = 0;
    rx_byte(8'h09, 2'b00);
    idle(TIMEOUT - 2);
    total++;
    if (master_state !== 4'd10) begin
      bad++;
      $display("FAIL watchdog_early: state=%0d, required 10", master_state);
    end
    wait_state(4'd9, 4, "watchdog_resync");
    send_packet(8'h0C, 8'h10, 8'h20);
    total++;
    if (intr_count !== 1) begin
      bad++;
      $display("FAIL watchdog_intr_count: got %0d, required 1", intr_count);
    end
  endtask
`endif

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_nominal_init();
    test_bad_ack();
    test_timeout();
    test_streaming();
    test_packet_error();
    test_async_reset();
`ifdef MOUSE_WATCHDOG_EN
    test_watchdog();
`endif
    idle(3);
    total++;
    if (exp_q.size() != 0 || exp_pkt_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: cmd=%0d pkt=%0d left, required 0/0",
               exp_q.size(), exp_pkt_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
